// File: rtl/ifetch.sv
// Instruction fetch stage: issues sequential word fetches on a request/grant port,
// buffers in-order responses in a prefetch FIFO and supports redirect with flush.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] idata,
    output logic [31:0] ipc,
    output logic        ivalid,
    input  logic        iready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misalign
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_pc_d   [DEPTH];
    logic [PW-1:0] fifo_rd_q, fifo_rd_d;
    logic [PW-1:0] fifo_wr_q, fifo_wr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [31:0]   aq_pc_q [DEPTH];
    logic [31:0]   aq_pc_d [DEPTH];
    logic [PW-1:0] aq_rd_q, aq_rd_d;
    logic [PW-1:0] aq_wr_q, aq_wr_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          misalign_q, misalign_d;
    logic [31:0]   ipc_hold_q, ipc_hold_d;

    logic          fifo_empty;
    logic          pop;
    logic          issue;
    logic          resp_keep;
    logic          resp_drop;
    logic          credit_ok;
    logic [CW:0]   credit_used;
    logic [31:0]   head_data;
    logic [31:0]   head_pc;

    // Handshakes: a fetch is issued when imem_req && imem_gnt at a rising edge;
    // an instruction is consumed when ivalid && iready at a rising edge.
    // Redirect overrides both: nothing issued, pushed or popped that cycle.
    always_comb begin
        fifo_empty = (fifo_cnt_q == '0);
        head_data  = fifo_data_q[fifo_rd_q];
        head_pc    = fifo_pc_q[fifo_rd_q];
        ivalid     = !fifo_empty;
        idata      = fifo_empty ? NOP : head_data;
        ipc        = fifo_empty ? ipc_hold_q : head_pc;
        pop        = ivalid && iready;
        // A slot freed by this cycle's pop can be reused by this cycle's issue.
        credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q} - (CW+1)'(pop);
        credit_ok   = credit_used < {1'b0, DEPTH_C};
        imem_req    = !rst && !redirect && credit_ok;
        imem_addr   = fpc_q;
        issue       = imem_req && imem_gnt;
        resp_keep   = imem_rvalid && (drop_q == '0);
        resp_drop   = imem_rvalid && (drop_q != '0);
        misalign    = misalign_q;
    end

    always_comb begin
        fpc_d       = fpc_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_cnt_d  = fifo_cnt_q;
        aq_pc_d     = aq_pc_q;
        aq_rd_d     = aq_rd_q;
        aq_wr_d     = aq_wr_q;
        inflight_d  = inflight_q;
        drop_d      = drop_q;
        misalign_d  = redirect && (redirect_pc[1:0] != 2'b00);
        ipc_hold_d  = ivalid ? head_pc : ipc_hold_q;

        if (redirect) begin
            fpc_d      = {redirect_pc[31:2], 2'b00};
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_cnt_d = '0;
            aq_rd_d    = '0;
            aq_wr_d    = '0;
            // Everything still outstanding becomes a response to throw away.
            inflight_d = inflight_q - CW'(imem_rvalid);
            drop_d     = inflight_q - CW'(imem_rvalid);
        end else begin
            if (issue) begin
                fpc_d            = fpc_q + 32'd4;
                aq_pc_d[aq_wr_q] = fpc_q;
                aq_wr_d          = aq_wr_q + PW'(1);
            end
            if (resp_keep) begin
                fifo_data_d[fifo_wr_q] = imem_rdata;
                fifo_pc_d[fifo_wr_q]   = aq_pc_q[aq_rd_q];
                fifo_wr_d              = fifo_wr_q + PW'(1);
                aq_rd_d                = aq_rd_q + PW'(1);
            end
            if (resp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + PW'(1);
            end
            inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid);
            fifo_cnt_d = fifo_cnt_q + CW'(resp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q       <= RESET_PC;
            fifo_data_q <= '{default: '0};
            fifo_pc_q   <= '{default: '0};
            fifo_rd_q   <= '0;
            fifo_wr_q   <= '0;
            fifo_cnt_q  <= '0;
            aq_pc_q     <= '{default: '0};
            aq_rd_q     <= '0;
            aq_wr_q     <= '0;
            inflight_q  <= '0;
            drop_q      <= '0;
            misalign_q  <= 1'b0;
            ipc_hold_q  <= RESET_PC;
        end else begin
            fpc_q       <= fpc_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            aq_pc_q     <= aq_pc_d;
            aq_rd_q     <= aq_rd_d;
            aq_wr_q     <= aq_wr_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            misalign_q  <= misalign_d;
            ipc_hold_q  <= ipc_hold_d;
        end
    end

endmodule
